// File: rtl/seven_seg_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    localparam int DIGIT_W = 32;
    localparam int MASK_W  = 8;

    localparam logic [MASK_W-1:0] BLANK_MASK = 8'hFF;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_DWELL_CYCLES = 50_000_000;
    localparam int DEF_BLANK_CYCLES = 1_000_000;
    localparam int DEF_REFRESH_DIV  = 100_000;

    // Counters for a range of 1 still need a one-bit register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_seg_display_arbiter_rr_pick.sv
// Round-robin chooser: first requester at or after ptr_i (wrapping),
// optionally skipping one index.
module rr_pick
    import seven_seg_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int PW = cnt_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          excl_en_i,
    input  logic [PW-1:0] excl_idx_i,
    output logic [PW-1:0] idx_o,
    output logic          found_o
);

    always_comb begin
        int j;
        j       = 0;
        idx_o   = '0;
        found_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found_o && req_i[PW'(j)] &&
                !(excl_en_i && (excl_idx_i == PW'(j)))) begin
                found_o = 1'b1;
                idx_o   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/seven_seg_display_arbiter.sv
// Round-robin owner of a shared 8-digit seven-segment driver, with minimum
// dwell per grant, a blanking gap between owners and a digit-refresh strobe.
module seven_seg_display_arbiter
    import seven_seg_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int REFRESH_DIV  = DEF_REFRESH_DIV
) (
    input  logic                       clk,
    input  logic                       RESET,
    input  logic [NUM_REQ-1:0]         REQ,
    input  logic [DIGIT_W*NUM_REQ-1:0] REQ_NUMBER,
    input  logic [MASK_W*NUM_REQ-1:0]  REQ_MASK,
    output logic [NUM_REQ-1:0]         GNT,
    output logic [DIGIT_W-1:0]         NUMBER,
    output logic [MASK_W-1:0]          AN_MASK,
    output logic                       DIGIT_TICK,
    output logic                       BUSY
);

    localparam int PW   = cnt_width(NUM_REQ);
    localparam int DW   = cnt_width(DWELL_CYCLES);
    localparam int BW   = cnt_width(BLANK_CYCLES);
    localparam int DIVW = cnt_width(REFRESH_DIV);

    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0]   BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]   IDX_LAST   = PW'(NUM_REQ - 1);

    state_e               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        cand_q, cand_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [DIGIT_W-1:0]   number_q, number_d;
    logic [MASK_W-1:0]    mask_q, mask_d;
    logic [BW-1:0]        blankCnt_q, blankCnt_d;
    logic [DW-1:0]        dwellCnt_q, dwellCnt_d;
    logic [DIVW-1:0]      div_q;

    logic [DIGIT_W-1:0]   reqNum  [NUM_REQ];
    logic [MASK_W-1:0]    reqMask [NUM_REQ];

    logic [PW-1:0]        pickIdx;
    logic                 pickFound;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign reqNum[i]  = REQ_NUMBER[DIGIT_W*i +: DIGIT_W];
        assign reqMask[i] = REQ_MASK[MASK_W*i +: MASK_W];
    end

    // While showing, the current owner is never a candidate for the next
    // gap; elsewhere nobody is excluded.
    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req_i      (REQ),
        .ptr_i      (ptr_q),
        .excl_en_i  (state_q == SHOW),
        .excl_idx_i (owner_q),
        .idx_o      (pickIdx),
        .found_o    (pickFound)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cand_d     = cand_q;
        owner_d    = owner_q;
        gnt_d      = gnt_q;
        number_d   = number_q;
        mask_d     = mask_q;
        blankCnt_d = blankCnt_q;
        dwellCnt_d = dwellCnt_q;

        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                mask_d = BLANK_MASK;
                if (pickFound) begin
                    cand_d     = pickIdx;
                    blankCnt_d = '0;
                    state_d    = BLANK;
                end
            end

            BLANK: begin
                gnt_d  = '0;
                mask_d = BLANK_MASK;
                if (!REQ[cand_q]) begin
                    if (pickFound) begin
                        cand_d     = pickIdx;
                        blankCnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (blankCnt_q == BLANK_LAST) begin
                    gnt_d          = '0;
                    gnt_d[cand_q]  = 1'b1;
                    owner_d        = cand_q;
                    ptr_d          = (cand_q == IDX_LAST) ? '0 : cand_q + PW'(1);
                    dwellCnt_d     = '0;
                    state_d        = SHOW;
                end else begin
                    blankCnt_d = blankCnt_q + BW'(1);
                end
            end

            SHOW: begin
                if (!REQ[owner_q]) begin
                    gnt_d  = '0;
                    mask_d = BLANK_MASK;
                    if (pickFound) begin
                        cand_d     = pickIdx;
                        blankCnt_d = '0;
                        state_d    = BLANK;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    number_d = reqNum[owner_q];
                    mask_d   = reqMask[owner_q];
                    if (dwellCnt_q != DWELL_LAST) begin
                        dwellCnt_d = dwellCnt_q + DW'(1);
                    end else if (pickFound) begin
                        gnt_d      = '0;
                        mask_d     = BLANK_MASK;
                        cand_d     = pickIdx;
                        blankCnt_d = '0;
                        state_d    = BLANK;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cand_q     <= '0;
            owner_q    <= '0;
            gnt_q      <= '0;
            number_q   <= '0;
            mask_q     <= BLANK_MASK;
            blankCnt_q <= '0;
            dwellCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cand_q     <= cand_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            number_q   <= number_d;
            mask_q     <= mask_d;
            blankCnt_q <= blankCnt_d;
            dwellCnt_q <= dwellCnt_d;
        end
    end

    // The refresh divider runs regardless of who owns the display.
    always_ff @(posedge clk) begin
        if (RESET) begin
            div_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIVW'(1);
        end
    end

    assign GNT        = gnt_q;
    assign NUMBER     = number_q;
    assign AN_MASK    = mask_q;
    assign DIGIT_TICK = (div_q == DIV_LAST);
    assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Directed self-checking bench for seven_seg_display_arbiter
// (NUM_REQ=4, DWELL=8, BLANK=2, REFRESH_DIV=4).
module tb_seven_seg_display_arbiter;

    localparam int SEL_GNT  = 0;
    localparam int SEL_MASK = 1;
    localparam int SEL_NUM  = 2;
    localparam int SEL_BUSY = 3;
    localparam int SEL_TICK = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic          clk;
    logic          RESET;
    logic [3:0]    REQ;
    logic [127:0]  REQ_NUMBER;
    logic [31:0]   REQ_MASK;
    logic [3:0]    GNT;
    logic [31:0]   NUMBER;
    logic [7:0]    AN_MASK;
    logic          DIGIT_TICK;
    logic          BUSY;

    exp_t          expQ[$];
    int            errCount;
    int            checkCount;
    int            since;
    logic [31:0]   numTab  [4];
    logic [7:0]    maskTab [4];

    seven_seg_display_arbiter #(
        .NUM_REQ      (4),
        .DWELL_CYCLES (8),
        .BLANK_CYCLES (2),
        .REFRESH_DIV  (4)
    ) dut (
        .clk        (clk),
        .RESET      (RESET),
        .REQ        (REQ),
        .REQ_NUMBER (REQ_NUMBER),
        .REQ_MASK   (REQ_MASK),
        .GNT        (GNT),
        .NUMBER     (NUMBER),
        .AN_MASK    (AN_MASK),
        .DIGIT_TICK (DIGIT_TICK),
        .BUSY       (BUSY)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rst, input logic [3:0] req);
        RESET = rst;
        REQ   = req;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        expQ.push_back(e);
    endtask

    function automatic logic [31:0] observed(input int sel);
        case (sel)
            SEL_GNT:  return {28'h0, GNT};
            SEL_MASK: return {24'h0, AN_MASK};
            SEL_NUM:  return NUMBER;
            SEL_BUSY: return {31'h0, BUSY};
            default:  return {31'h0, DIGIT_TICK};
        endcase
    endfunction

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        while (expQ.size() > 0) begin
            e   = expQ.pop_front();
            obs = observed(e.sel);
            checkCount++;
            assert (obs === e.val) else begin
                errCount++;
                $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 4'b0000);
        cycle();
        applyStimulus(1'b0, 4'b0000);
    endtask

    initial begin
        clk        = 1'b0;
        errCount   = 0;
        checkCount = 0;
        numTab[0]  = 32'hDEAD0000;
        numTab[1]  = 32'h1234ABCD;
        numTab[2]  = 32'h22220002;
        numTab[3]  = 32'h33330003;
        maskTab[0] = 8'h00;
        maskTab[1] = 8'h0F;
        maskTab[2] = 8'hF0;
        maskTab[3] = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            REQ_NUMBER[32*i +: 32] = numTab[i];
            REQ_MASK[8*i +: 8]     = maskTab[i];
        end

        // Reset held with every requester asking
        applyStimulus(1'b1, 4'hF);
        for (int i = 0; i < 3; i++) begin
            pushExp("rst_gnt", SEL_GNT, 32'h0);
            pushExp("rst_mask", SEL_MASK, 32'hFF);
            pushExp("rst_num", SEL_NUM, 32'h0);
            pushExp("rst_busy", SEL_BUSY, 32'h0);
            pushExp("rst_tick", SEL_TICK, 32'h0);
            cycle();
            checkOutput();
        end

        // Single requester: grant after the blank gap, data one cycle later
        applyStimulus(1'b0, 4'b0010);
        pushExp("one_e0_gnt", SEL_GNT, 32'h0);
        pushExp("one_e0_busy", SEL_BUSY, 32'h1);
        pushExp("one_e0_mask", SEL_MASK, 32'hFF);
        cycle();
        checkOutput();
        pushExp("one_e1_gnt", SEL_GNT, 32'h0);
        cycle();
        checkOutput();
        pushExp("one_e2_gnt", SEL_GNT, 32'h2);
        pushExp("one_e2_mask", SEL_MASK, 32'hFF);
        pushExp("one_e2_num", SEL_NUM, 32'h0);
        cycle();
        checkOutput();
        for (int i = 0; i < 12; i++) begin
            pushExp("one_hold_gnt", SEL_GNT, 32'h2);
            pushExp("one_hold_num", SEL_NUM, 32'h1234ABCD);
            pushExp("one_hold_mask", SEL_MASK, 32'h0F);
            cycle();
            checkOutput();
        end
        REQ_NUMBER[63:32] = 32'h5555AAAA;
        pushExp("one_newnum", SEL_NUM, 32'h5555AAAA);
        cycle();
        checkOutput();
        REQ_NUMBER[63:32] = numTab[1];
        applyStimulus(1'b0, 4'b0000);
        pushExp("one_drop_gnt", SEL_GNT, 32'h0);
        pushExp("one_drop_mask", SEL_MASK, 32'hFF);
        pushExp("one_drop_busy", SEL_BUSY, 32'h0);
        cycle();
        checkOutput();

        // All four requesting: rotation 0,1,2,3,0 with 8-cycle grants and 2-cycle gaps
        doReset();
        applyStimulus(1'b0, 4'hF);
        for (int m = 0; m < 44; m++) begin
            int r;
            int own;
            if (m < 2) begin
                pushExp("rr_gnt", SEL_GNT, 32'h0);
                pushExp("rr_mask", SEL_MASK, 32'hFF);
            end else begin
                r   = (m - 2) % 10;
                own = ((m - 2) / 10) % 4;
                pushExp("rr_gnt", SEL_GNT, (r < 8) ? (32'h1 << own) : 32'h0);
                if (r >= 1 && r <= 7) begin
                    pushExp("rr_mask", SEL_MASK, {24'h0, maskTab[own]});
                    pushExp("rr_num", SEL_NUM, numTab[own]);
                end else begin
                    pushExp("rr_mask", SEL_MASK, 32'hFF);
                end
            end
            cycle();
            checkOutput();
        end

        // Owner 2 drops early while requester 0 waits
        doReset();
        applyStimulus(1'b0, 4'b0100);
        cycle();
        cycle();
        pushExp("drop_grant2", SEL_GNT, 32'h4);
        cycle();
        checkOutput();
        cycle();
        cycle();
        applyStimulus(1'b0, 4'b0101);
        pushExp("drop_keep2", SEL_GNT, 32'h4);
        pushExp("drop_keep2_mask", SEL_MASK, 32'hF0);
        cycle();
        checkOutput();
        applyStimulus(1'b0, 4'b0001);
        pushExp("drop_gap0_gnt", SEL_GNT, 32'h0);
        pushExp("drop_gap0_mask", SEL_MASK, 32'hFF);
        pushExp("drop_gap0_busy", SEL_BUSY, 32'h1);
        cycle();
        checkOutput();
        pushExp("drop_gap1_gnt", SEL_GNT, 32'h0);
        pushExp("drop_gap1_mask", SEL_MASK, 32'hFF);
        cycle();
        checkOutput();
        pushExp("drop_grant0", SEL_GNT, 32'h1);
        cycle();
        checkOutput();
        pushExp("drop_num0", SEL_NUM, numTab[0]);
        pushExp("drop_mask0", SEL_MASK, 32'h00);
        pushExp("drop_gnt0_hold", SEL_GNT, 32'h1);
        cycle();
        checkOutput();

        // Candidate withdraws during the gap: re-pick restarts the gap
        doReset();
        applyStimulus(1'b0, 4'b1001);
        pushExp("repick_e0_gnt", SEL_GNT, 32'h0);
        pushExp("repick_e0_busy", SEL_BUSY, 32'h1);
        cycle();
        checkOutput();
        applyStimulus(1'b0, 4'b1000);
        pushExp("repick_e1_gnt", SEL_GNT, 32'h0);
        pushExp("repick_e1_mask", SEL_MASK, 32'hFF);
        cycle();
        checkOutput();
        pushExp("repick_e2_gnt", SEL_GNT, 32'h0);
        cycle();
        checkOutput();
        pushExp("repick_grant3", SEL_GNT, 32'h8);
        cycle();
        checkOutput();

        // Candidate withdraws during the gap with nobody else: back to idle
        doReset();
        applyStimulus(1'b0, 4'b0010);
        pushExp("idle_e0_busy", SEL_BUSY, 32'h1);
        cycle();
        checkOutput();
        applyStimulus(1'b0, 4'b0000);
        pushExp("idle_e1_busy", SEL_BUSY, 32'h0);
        pushExp("idle_e1_gnt", SEL_GNT, 32'h0);
        pushExp("idle_e1_mask", SEL_MASK, 32'hFF);
        cycle();
        checkOutput();
        pushExp("idle_e2_busy", SEL_BUSY, 32'h0);
        cycle();
        checkOutput();

        // Refresh strobe free-running, reset pulsed mid-grant
        applyStimulus(1'b1, 4'b0100);
        cycle();
        applyStimulus(1'b0, 4'b0100);
        since = 0;
        for (int m = 1; m <= 20; m++) begin
            if (m == 9) begin
                applyStimulus(1'b1, 4'b1010);
            end else if (m == 10) begin
                applyStimulus(1'b0, 4'b1010);
            end
            since = (m == 9) ? 0 : since + 1;
            pushExp("tick", SEL_TICK, {31'h0, (since % 4) == 3});
            if (m == 3 || m == 8) begin
                pushExp("tick_show_gnt", SEL_GNT, 32'h4);
            end
            if (m == 9) begin
                pushExp("midrst_gnt", SEL_GNT, 32'h0);
                pushExp("midrst_busy", SEL_BUSY, 32'h0);
                pushExp("midrst_mask", SEL_MASK, 32'hFF);
                pushExp("midrst_num", SEL_NUM, 32'h0);
            end
            if (m == 12) begin
                pushExp("midrst_ptr0_gnt", SEL_GNT, 32'h2);
            end
            cycle();
            checkOutput();
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
